// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared edge/center-aligned counter, double-buffered
// duty/period/mode registers swapped at period boundaries, and immediate output polarity.
module pwm_multi_channel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start,
    output logic [WIDTH-1:0]    cnt
);
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = ADDR_W'(CHANNELS);
    localparam logic [ADDR_W-1:0] ADDR_MODE   = ADDR_W'(CHANNELS + 1);
    localparam logic [ADDR_W-1:0] ADDR_POL    = ADDR_W'(CHANNELS + 2);
    localparam logic [WIDTH-1:0]  CNT_ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]  CNT_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0]  CNT_ONES    = {WIDTH{1'b1}};

    logic [WIDTH-1:0]    duty_shd_r [CHANNELS];
    logic [WIDTH-1:0]    duty_act_r [CHANNELS];
    logic [WIDTH-1:0]    period_shd_r;
    logic [WIDTH-1:0]    period_act_r;
    logic                mode_shd_r;
    logic                mode_act_r;
    logic [CHANNELS-1:0] pol_r;
    logic [WIDTH-1:0]    cnt_r;
    logic                dir_down_r;

    logic [WIDTH-1:0]    cnt_nxt_s;
    logic                dir_down_nxt_s;
    logic                load_s;
    logic [CHANNELS-1:0] cmp_s;

    // Counter next-state: edge mode wraps at period, center mode bounces between 0 and period
    always_comb begin
        cnt_nxt_s      = CNT_ZERO;
        dir_down_nxt_s = 1'b0;
        if (!en || (period_act_r == CNT_ZERO)) begin
            cnt_nxt_s      = CNT_ZERO;
            dir_down_nxt_s = 1'b0;
        end else if (!mode_act_r) begin
            cnt_nxt_s      = (cnt_r >= period_act_r) ? CNT_ZERO : (cnt_r + CNT_ONE);
            dir_down_nxt_s = 1'b0;
        end else if (dir_down_r && (cnt_r != CNT_ZERO)) begin
            cnt_nxt_s      = cnt_r - CNT_ONE;
            dir_down_nxt_s = (cnt_r != CNT_ONE);
        end else if (cnt_r >= period_act_r) begin
            // Top of the triangle; with period 1 the step lands on 0 and stays in up phase
            cnt_nxt_s      = period_act_r - CNT_ONE;
            dir_down_nxt_s = (period_act_r != CNT_ONE);
        end else begin
            cnt_nxt_s      = cnt_r + CNT_ONE;
            dir_down_nxt_s = 1'b0;
        end
    end

    // Active registers follow their shadows while idle and at every period boundary
    assign load_s = !en || (cnt_nxt_s == CNT_ZERO);

    // Counter, direction and active register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= CNT_ZERO;
            dir_down_r   <= 1'b0;
            period_act_r <= CNT_ONES;
            mode_act_r   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_act_r[i] <= CNT_ZERO;
            end
        end else begin
            cnt_r      <= cnt_nxt_s;
            dir_down_r <= dir_down_nxt_s;
            if (load_s) begin
                period_act_r <= period_shd_r;
                mode_act_r   <= mode_shd_r;
                for (int i = 0; i < CHANNELS; i++) begin
                    duty_act_r[i] <= duty_shd_r[i];
                end
            end
        end
    end

    // Host register writes; a write on a boundary edge only reaches the shadow
    always_ff @(posedge clk) begin
        if (rst) begin
            period_shd_r <= CNT_ONES;
            mode_shd_r   <= 1'b0;
            pol_r        <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                duty_shd_r[i] <= CNT_ZERO;
            end
        end else if (wr_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    duty_shd_r[i] <= wr_data;
                end
            end
            if (wr_addr == ADDR_PERIOD) begin
                period_shd_r <= wr_data;
            end
            if (wr_addr == ADDR_MODE) begin
                mode_shd_r <= wr_data[0];
            end
            if (wr_addr == ADDR_POL) begin
                pol_r <= wr_data[CHANNELS-1:0];
            end
        end
    end

    // Per-channel duty comparators against the shared counter
    always_comb begin
        cmp_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            cmp_s[i] = (cnt_r < duty_act_r[i]);
        end
    end

    assign pwm_out      = ({CHANNELS{en}} & cmp_s) ^ pol_r;
    assign period_start = en && (cnt_r == CNT_ZERO);
    assign cnt          = cnt_r;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: directed scenarios plus random traffic,
// compared against a period-position model of the PWM rules.
module tb_pwm_multi_channel;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int ADDR_W   = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WIDTH-1:0]    wr_data;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_start;
    logic [WIDTH-1:0]    cnt;

    always #5 clk = ~clk;

    pwm_multi_channel #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .pwm_out(pwm_out), .period_start(period_start), .cnt(cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: position inside the current period rather than counter + direction
    int         m_duty_shd [4];
    int         m_duty_act [4];
    int         m_per_shd, m_per_act;
    int         m_mode_shd, m_mode_act;
    logic [3:0] m_pol;
    int         m_pos;

    logic [31:0] hist [4];
    int          ps_count;
    int          center_seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_len();
        if (m_per_act == 0) return 1;
        else if (m_mode_act == 1) return 2 * m_per_act;
        else return m_per_act + 1;
    endfunction

    function automatic int m_cnt();
        if (m_mode_act == 1 && m_pos > m_per_act) return 2 * m_per_act - m_pos;
        else return m_pos;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_duty_shd[i] = 0;
            m_duty_act[i] = 0;
        end
        m_per_shd = 255; m_per_act = 255;
        m_mode_shd = 0;  m_mode_act = 0;
        m_pol = 4'b0000; m_pos = 0;
    endtask

    task automatic model_load();
        for (int i = 0; i < 4; i++) m_duty_act[i] = m_duty_shd[i];
        m_per_act  = m_per_shd;
        m_mode_act = m_mode_shd;
    endtask

    task automatic model_edge(input logic r, input logic e, input logic w,
                              input logic [2:0] a, input logic [7:0] d);
        if (r) begin
            model_reset();
        end else begin
            if (!e || (m_pos + 1 >= m_len())) begin
                m_pos = 0;
                model_load();
            end else begin
                m_pos = m_pos + 1;
            end
            if (w) begin
                if (a < 3'd4) m_duty_shd[int'(a)] = int'(d);
                else if (a == 3'd4) m_per_shd = int'(d);
                else if (a == 3'd5) m_mode_shd = int'(d[0]);
                else if (a == 3'd6) m_pol = d[3:0];
            end
        end
    endtask

    task automatic check_outputs(input logic e);
        int c;
        logic [3:0] ep;
        c = m_cnt();
        for (int i = 0; i < 4; i++) ep[i] = ((e && (c < m_duty_act[i])) ? 1'b1 : 1'b0) ^ m_pol[i];
        chk("cnt", 32'(cnt), 32'(c));
        chk("pwm_out", 32'(pwm_out), 32'(ep));
        chk("period_start", 32'(period_start), 32'(e && (c == 0)));
    endtask

    task automatic step(input logic r, input logic e, input logic w,
                        input logic [2:0] a, input logic [7:0] d);
        rst = r; en = e; wr_en = w; wr_addr = a; wr_data = d;
        #1;
        check_outputs(e);
        for (int i = 0; i < 4; i++) hist[i] = {hist[i][30:0], pwm_out[i]};
        if (period_start) ps_count++;
        @(posedge clk);
        model_edge(r, e, w, a, d);
        @(negedge clk);
    endtask

    task automatic idle_until(input logic [7:0] target);
        int k;
        k = 0;
        while (cnt !== target && k < 64) begin
            step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
            k++;
        end
        chk("wait_cnt", 32'(cnt), 32'(target));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) hist[i] = 32'd0;
        ps_count = 0;
        rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset state
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        chk("reset_cnt", 32'(cnt), 32'd0);
        chk("reset_pwm", 32'(pwm_out), 32'd0);
        chk("reset_ps", 32'(period_start), 32'd0);

        // Edge mode, period 9, duties 3 / 0 / 10 / 9
        step(1'b0, 1'b0, 1'b1, 3'd4, 8'd9);
        step(1'b0, 1'b0, 1'b1, 3'd0, 8'd3);
        step(1'b0, 1'b0, 1'b1, 3'd1, 8'd0);
        step(1'b0, 1'b0, 1'b1, 3'd2, 8'd10);
        step(1'b0, 1'b0, 1'b1, 3'd3, 8'd9);
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        ps_count = 0;
        repeat (10) step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
        chk("edge_ch0", 32'(hist[0][9:0]), 32'(10'b1110000000));
        chk("duty_zero_ch1", 32'(hist[1][9:0]), 32'(10'b0000000000));
        chk("duty_over_ch2", 32'(hist[2][9:0]), 32'(10'b1111111111));
        chk("duty_eq_ch3", 32'(hist[3][9:0]), 32'(10'b1111111110));
        repeat (10) step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
        chk("edge_ch0_p2", 32'(hist[0][9:0]), 32'(10'b1110000000));
        chk("edge_ps_count", 32'(ps_count), 32'd2);

        // Shadowing: mid-period write, then write on the update edge
        idle_until(8'd4);
        step(1'b0, 1'b1, 1'b1, 3'd0, 8'd5);
        idle_until(8'd0);
        chk("shadow_cur_low", 32'(hist[0][5:0]), 32'd0);
        repeat (10) step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
        chk("shadow_next", 32'(hist[0][9:0]), 32'(10'b1111100000));
        idle_until(8'd9);
        step(1'b0, 1'b1, 1'b1, 3'd0, 8'd7);
        repeat (10) step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
        chk("upd_edge_hold", 32'(hist[0][9:0]), 32'(10'b1111100000));
        repeat (10) step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
        chk("upd_edge_late", 32'(hist[0][9:0]), 32'(10'b1111111000));

        // Center mode, period 4, duty0 2
        step(1'b0, 1'b0, 1'b1, 3'd4, 8'd4);
        step(1'b0, 1'b0, 1'b1, 3'd5, 8'd1);
        step(1'b0, 1'b0, 1'b1, 3'd0, 8'd2);
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        ps_count = 0;
        for (int k = 0; k < 8; k++) begin
            chk("center_seq", 32'(cnt), 32'(center_seq[k]));
            step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
        end
        chk("center_ch0", 32'(hist[0][7:0]), 32'(8'b11000001));
        repeat (8) step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
        chk("center_ps_count", 32'(ps_count), 32'd2);

        // Polarity write mid-period, then enable drop and re-raise
        repeat (3) step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 3'd6, 8'd1);
        chk("pol_inv", 32'(pwm_out[0]), 32'd1);
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        chk("en_off_cnt", 32'(cnt), 32'd0);
        chk("en_off_pwm", 32'(pwm_out), 32'(4'b0001));
        chk("en_off_ps", 32'(period_start), 32'd0);
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
        chk("en_restart", 32'(cnt), 32'd1);

        // Reset at cnt=3 on the down slope
        idle_until(8'd4);
        idle_until(8'd3);
        step(1'b1, 1'b1, 1'b0, 3'd0, 8'd0);
        chk("midrst_cnt", 32'(cnt), 32'd0);
        chk("midrst_pwm", 32'(pwm_out), 32'd0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic       r_v, e_v, w_v;
            logic [2:0] a_v;
            logic [7:0] d_v;
            r_v = ($urandom_range(0, 99) == 0);
            e_v = ($urandom_range(0, 9) != 0);
            w_v = ($urandom_range(0, 3) == 0);
            a_v = 3'($urandom_range(0, 7));
            d_v = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            step(r_v, e_v, w_v, a_v, d_v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of the sequence");
        $fatal(1, "time limit");
    end

endmodule
